ctrl_fsm: RTL
=============

CTRL_FSM -- requirements
Module: ctrl_fsm

Parameters
REQ-001 The block SHALL expose parameter OPWIDTH, default 3, giving the ALUOp output width (up to 8 ALU operations at default).
REQ-002 The block SHALL expose parameter MCODEBITS, default 4, giving the opcode input width; MCODEBITS >= OPWIDTH.
REQ-003 The block SHALL expose parameter MEM_TIMEOUT, default 15, giving the maximum cycles to wait for mem_ready; range 1..255.

Interface
REQ-004 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, which leaves IDLE/HALT.
REQ-007 The block SHALL have port instr, input, MCODEBITS, the opcode from instruction memory, valid in FETCH.
REQ-008 The block SHALL have port mem_ready, input, 1, the data-memory completion handshake.
REQ-009 The block SHALL have port zero, input, 1, the ALU zero flag, sampled in EXEC.
REQ-010 The block SHALL have outputs RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, MemRead, PCWrite, IRWrite, each 1 bit, carrying the datapath controls.
REQ-011 The block SHALL have output ALUOp, OPWIDTH bits, the ALU operation select.
REQ-012 The block SHALL have outputs done, 1 bit, halted normally, and err, 1 bit, halted on memory timeout.
REQ-013 The block SHALL have output state, 3 bits, the current state encoding for debug.

Function
REQ-014 The states SHALL be encoded IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; encoding 7 SHALL go to HALT with err=1.
REQ-015 IDLE SHALL go to FETCH when start=1 and stay in IDLE otherwise.
REQ-016 FETCH SHALL last 1 cycle with IRWrite=1 and PCWrite=1; the opcode register SHALL capture instr on that edge; the next state SHALL be DECODE.
REQ-017 DECODE SHALL last 1 cycle with no strobes asserted; an opcode of all ones SHALL go to HALT, and any other opcode SHALL go to EXEC.
REQ-018 EXEC SHALL last 1 cycle with ALUOp driven from the opcode register.
  - opcode 0000 store: ALUSrc=1, ALUOp=111; next state MEM.
  - opcode 0010 load: ALUSrc=1, ALUOp=111; next state MEM.
  - opcode 0011 branch: Branch=1, ALUOp=001 (subtract); PCWrite=zero; next state FETCH.
  - opcode 0001 add: ALUOp=000; next state WB.
  - any other opcode: ALUOp=opcode[OPWIDTH-1:0]; next state WB.
REQ-019 MEM SHALL assert MemWrite=1 for a store or MemRead=1 for a load, held every cycle until mem_ready=1.
  - On mem_ready=1, a store SHALL go to FETCH and a load SHALL go to WB.
REQ-020 MEM SHALL count its cycles in an 8-bit wait counter cleared on MEM entry.
  - If the counter reaches MEM_TIMEOUT with mem_ready=0, the next state SHALL be HALT with err=1.
  - If mem_ready=1 in that same cycle, the handshake SHALL win.
REQ-021 WB SHALL last 1 cycle with RegWrite=1, MemtoReg=1 for a load and 0 otherwise; the next state SHALL be FETCH.
REQ-022 RegWrite SHALL be 0 in every state except WB, and RegDst SHALL always be 0.
REQ-023 HALT SHALL hold done=1 (normal halt) or err=1 (timeout or illegal state) with every strobe at 0.
  - start=1 in HALT SHALL go to FETCH and clear done and err on that edge.
REQ-024 All control outputs SHALL be combinational functions of state, the opcode register and the inputs named above.
  - No output SHALL depend on instr outside FETCH.
REQ-025 A start pulse in any state other than IDLE or HALT SHALL be ignored.

Reset
REQ-026 While Reset=0, the state register SHALL be IDLE immediately, regardless of Clk.
REQ-027 While Reset=0, the opcode register, wait counter, done and err SHALL be 0.
REQ-028 During and after reset, all strobes SHALL be 0 and ALUOp=111.
REQ-029 Reset asserted mid-MEM SHALL drop MemWrite/MemRead in the same cycle, with no partial state retained.

Verification
REQ-030 Reset release, then start=1 with instr=0001 SHALL give state 1,2,3,5,1; ALUOp=000 in EXEC; RegWrite=1 only in WB.
REQ-031 Load (0010) with mem_ready raised on the 3rd MEM cycle SHALL hold MemRead=1 for 3 cycles, then WB with MemtoReg=1 and RegWrite=1.
REQ-032 Store (0000) with mem_ready never high and MEM_TIMEOUT=15 SHALL hold MemWrite=1 for 15 cycles, then HALT, err=1, done=0; start=1 SHALL then give FETCH with err=0.
REQ-033 Branch (0011) SHALL give PCWrite=1 in EXEC when zero=1 and PCWrite=0 when zero=0, then FETCH in both cases.
REQ-034 Opcode 1111 SHALL give DECODE then HALT with done=1; start held high mid-instruction SHALL not alter the sequence.
REQ-035 Reset=0 asserted asynchronously in MEM with MemWrite=1 SHALL give state=0 and MemWrite=0 before the next Clk edge.

Source files
------------

// File: rtl/ctrl_fsm.sv
// Multicycle datapath control sequencer.
// FETCH/DECODE/EXEC/MEM/WB with a bounded memory handshake.
module ctrl_fsm #(
  parameter int OPWIDTH     = 3,
  parameter int MCODEBITS   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 mem_ready,
  input  logic                 zero,
  output logic                 RegDst,
  output logic                 Branch,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [MCODEBITS-1:0] OP_ST  = '0;
  localparam logic [MCODEBITS-1:0] OP_ADD = MCODEBITS'(1);
  localparam logic [MCODEBITS-1:0] OP_LD  = MCODEBITS'(2);
  localparam logic [MCODEBITS-1:0] OP_BR  = MCODEBITS'(3);
  localparam logic [MCODEBITS-1:0] OP_HLT = '1;
  // Counter holds completed MEM cycles, so the last allowed one is TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t               r_state;
  logic [MCODEBITS-1:0] r_op;
  logic [7:0]           r_wcnt;
  logic                 r_done;
  logic                 r_err;

  logic w_st;
  logic w_ld;
  logic w_br;
  logic w_add;

  assign w_st  = (r_op == OP_ST);
  assign w_ld  = (r_op == OP_LD);
  assign w_br  = (r_op == OP_BR);
  assign w_add = (r_op == OP_ADD);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_op    <= instr;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (r_op == OP_HLT) begin
            r_state <= S_HALT;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_wcnt <= '0;
          unique case (1'b1)
            w_st, w_ld: r_state <= S_MEM;
            w_br:       r_state <= S_FETCH;
            default:    r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= w_ld ? S_WB : S_FETCH;
          end else if (r_wcnt == TO_LAST) begin
            r_state <= S_HALT;
            r_err   <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
        end
        S_HALT: begin
          if (start) begin
            r_state <= S_FETCH;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_HALT;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    Branch   = 1'b0;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    ALUSrc   = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    ALUOp    = '1;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_EXEC: begin
        unique case (1'b1)
          w_st, w_ld: begin
            ALUSrc = 1'b1;
            ALUOp  = '1;
          end
          w_br: begin
            Branch  = 1'b1;
            ALUOp   = OPWIDTH'(1);
            PCWrite = zero;
          end
          w_add:   ALUOp = '0;
          default: ALUOp = r_op[OPWIDTH-1:0];
        endcase
      end
      S_MEM: begin
        MemWrite = w_st;
        MemRead  = w_ld;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = w_ld;
      end
      default: ;
    endcase
  end

  assign RegDst = 1'b0;
  assign done   = r_done;
  assign err    = r_err;
  assign state  = r_state;

endmodule
